// File: rtl/serializador_param_if.sv
// Word-side handshake between a parallel source and serializador_param.
// The source drives valid_in/data_in; the serializer returns ready_out and its fill level.
interface serializador_param_if #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic              valid_in;
    logic [DATA_W-1:0] data_in;
    logic              ready_out;
    logic [CNT_W-1:0]  fifo_count;

    modport master (output valid_in, data_in, input ready_out, fifo_count);
    modport slave  (input valid_in, data_in, output ready_out, fifo_count);
endinterface

// File: rtl/serializador_param.sv
// Parallel-to-serial transmitter: FIFO-buffered words go out MSB-first as gap-free frames,
// with an idle word whenever the FIFO is empty. Define SERIAL_PARITY_EN to append even parity.
module serializador_param #(
    parameter int                DATA_W     = 8,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [DATA_W-1:0] IDLE_WORD  = DATA_W'(8'hBC)
) (
    input  logic                 clk_32f,
    input  logic                 reset,
    serializador_param_if.slave  bus,
    output logic                 data_out,
    output logic                 frame_start,
    output logic                 frame_is_data
);
`ifdef SERIAL_PARITY_EN
    localparam int FRAME_W = DATA_W + 1;
`else
    localparam int FRAME_W = DATA_W;
`endif
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int BIT_W = $clog2(FRAME_W);

    typedef enum logic {LOAD, SHIFT} state_t;

    state_t             state_reg, state_next;
    logic [BIT_W-1:0]   bit_cnt_reg, bit_cnt_next;
    logic [FRAME_W-1:0] shift_reg;
    logic               is_data_reg;

    logic [DATA_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;

    logic               load_frame;
    logic               fifo_full, fifo_empty;
    logic               push, pop;
    logic [DATA_W-1:0]  load_word;
    logic [FRAME_W-1:0] load_bits;

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        load_frame   = 1'b0;
        case (state_reg)
            LOAD: begin
                load_frame   = 1'b1;
                state_next   = SHIFT;
                bit_cnt_next = '0;
            end
            SHIFT: begin
                // Last bit of a frame: reload on the same edge so frames stay back-to-back.
                if (bit_cnt_reg == BIT_W'(FRAME_W - 1)) begin
                    load_frame   = 1'b1;
                    bit_cnt_next = '0;
                end else begin
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    // Full is judged on registered state only, so a pop cannot make room for a same-edge push.
    assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_reg == '0);
    assign push       = bus.valid_in && !fifo_full;
    assign pop        = load_frame && !fifo_empty;
    assign load_word  = pop ? fifo_mem[rd_ptr_reg] : IDLE_WORD;

`ifdef SERIAL_PARITY_EN
    assign load_bits = {load_word, ^load_word};
`else
    assign load_bits = load_word;
`endif

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state_reg   <= LOAD;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            is_data_reg <= 1'b0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            if (load_frame) begin
                shift_reg   <= load_bits;
                is_data_reg <= pop;
            end else begin
                shift_reg   <= {shift_reg[FRAME_W-2:0], 1'b0};
            end
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk_32f) begin
        if (push) fifo_mem[wr_ptr_reg] <= bus.data_in;
    end

    assign data_out       = shift_reg[FRAME_W-1];
    assign frame_start    = (state_reg == SHIFT) && (bit_cnt_reg == '0);
    assign frame_is_data  = is_data_reg;
    assign bus.ready_out  = !fifo_full;
    assign bus.fifo_count = count_reg;
endmodule

// File: tb/tb_serializador_param.sv
// Randomised bench for serializador_param against a queue-based model of the serial stream.
// Compile with +define+SERIAL_PARITY_EN to exercise the parity frame format.
module tb_serializador_param;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam logic [DATA_W-1:0] IDLE = 8'hBC;
`ifdef SERIAL_PARITY_EN
    localparam int F = DATA_W + 1;
`else
    localparam int F = DATA_W;
`endif
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic clk_32f = 1'b0;
    logic reset;
    logic data_out, frame_start, frame_is_data;

    always #5 clk_32f = ~clk_32f;

    serializador_param_if #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

    serializador_param #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .IDLE_WORD(IDLE)) dut (
        .clk_32f       (clk_32f),
        .reset         (reset),
        .bus           (bus),
        .data_out      (data_out),
        .frame_start   (frame_start),
        .frame_is_data (frame_is_data)
    );

    // Model: queued words, the frame on the wire, and the bit position within it (-1 = not started).
    logic [DATA_W-1:0] q[$];
    logic [F-1:0]      frame_m;
    bit                isdata_m;
    int                pos;
    int                errors = 0;
    int                checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [F-1:0] mk_frame(input logic [DATA_W-1:0] w);
`ifdef SERIAL_PARITY_EN
        return {w, ^w};
`else
        return w;
`endif
    endfunction

    task automatic compare_all();
        if (pos < 0) begin
            check("data_out", data_out, 0);
            check("frame_start", frame_start, 0);
            check("frame_is_data", frame_is_data, 0);
        end else begin
            check("data_out", data_out, frame_m[F-1-pos]);
            check("frame_start", frame_start, pos == 0);
            check("frame_is_data", frame_is_data, isdata_m);
        end
        check("fifo_count", bus.fifo_count, q.size());
        check("ready_out", bus.ready_out, q.size() < FIFO_DEPTH);
    endtask

    task automatic model_reset();
        q.delete();
        pos      = -1;
        isdata_m = 1'b0;
        frame_m  = '0;
    endtask

    // One clock: update the model from the inputs present at the edge, then compare.
    task automatic step(output bit pushed);
        bit                v;
        logic [DATA_W-1:0] d;
        bit                ld;
        @(posedge clk_32f);
        v  = bus.valid_in;
        d  = bus.data_in;
        ld = (pos < 0) || (pos == F - 1);
        pushed = v && (q.size() < FIFO_DEPTH);
        if (ld) begin
            if (q.size() > 0) begin
                frame_m  = mk_frame(q.pop_front());
                isdata_m = 1'b1;
            end else begin
                frame_m  = mk_frame(IDLE);
                isdata_m = 1'b0;
            end
            pos = 0;
        end else begin
            pos++;
        end
        if (pushed) q.push_back(d);
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        bit p;
        for (int i = 0; i < n; i++) step(p);
    endtask

    // Present a word and hold it until accepted; valid_in stays high for the caller to drop.
    task automatic send(input logic [DATA_W-1:0] w);
        bit acc;
        int n;
        bus.valid_in = 1'b1;
        bus.data_in  = w;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            step(acc);
            n++;
        end
        check("accept_bound", acc, 1);
        $display("push %02h accepted after %0d cycles", w, n);
    endtask

    initial begin
        bit p;
        bit found;
        reset        = 1'b1;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        model_reset();
        #3;
        compare_all();
        @(posedge clk_32f);
        #1;
        compare_all();
        reset = 1'b0;

        $display("phase idle stream");
        run(3 * F);

        $display("phase burst FF EE DD");
        send(8'hFF);
        send(8'hEE);
        send(8'hDD);
        bus.valid_in = 1'b0;
        run(5 * F);

        $display("phase hold valid 01..05");
        for (int i = 0; i < 2 * F && pos != 0; i++) step(p);
        for (int w = 1; w <= 5; w++) send(DATA_W'(w));
        bus.valid_in = 1'b0;
        run(7 * F);

        $display("phase ignored AA then CC");
        bus.data_in = 8'hAA;
        run(3);
        send(8'hCC);
        bus.valid_in = 1'b0;
        run(3 * F);

        $display("phase random traffic");
        for (int i = 0; i < 800; i++) begin
            bus.valid_in = ($urandom_range(0, 3) != 0);
            bus.data_in  = DATA_W'($urandom);
            step(p);
        end
        bus.valid_in = 1'b0;
        run(2 * F);

        $display("phase reset mid-frame");
        send(8'hFF);
        send(8'h11);
        send(8'h22);
        bus.valid_in = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (isdata_m && frame_m == mk_frame(8'hFF) && pos == 3 && q.size() > 0)
                found = 1'b1;
            else
                step(p);
        end
        check("reset_setup", found, 1);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk_32f);
        #1;
        compare_all();
        reset = 1'b0;
        run(2 * F);
        send(8'h5A);
        bus.valid_in = 1'b0;
        run(3 * F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
